// File: rtl/axi_lite_slave_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_slave_regfile_if
//  Brief    : AXI4-Lite bus bundle with master and slave modports.
//  Revision : 1.0
// ============================================================================
interface axi_lite_slave_regfile_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic [ADDRESS_WIDTH-1:0]  AWADDR;
   logic [2:0]                AWPROT;
   logic                      AWVALID;
   logic                      AWREADY;
   logic [DATA_WIDTH-1:0]     WDATA;
   logic [DATA_WIDTH/8-1:0]   WSTRB;
   logic                      WVALID;
   logic                      WREADY;
   logic [1:0]                BRESP;
   logic                      BVALID;
   logic                      BREADY;
   logic [ADDRESS_WIDTH-1:0]  ARADDR;
   logic [2:0]                ARPROT;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                RRESP;
   logic                      RVALID;
   logic                      RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_slave_regfile
//  Brief    : AXI4-Lite slave with NUM_REGS byte-strobed registers exported
//             flat; optional decode errors via AXIL_SLV_DECODE_ERR_EN.
//  Revision : 1.0
// ============================================================================
module axi_lite_slave_regfile #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int NUM_REGS      = 16
) (
   input  wire logic                         ACLK,
   input  wire logic                         ARESETn,
   axi_lite_slave_regfile_if.slave           s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0]    reg_q,
   output logic [NUM_REGS-1:0]               reg_wr
);
   localparam int         c_STRB_W = DATA_WIDTH / 8;
   localparam int         c_OFFS   = $clog2(c_STRB_W);
   localparam logic [1:0] c_OKAY   = 2'b00;
   localparam logic [1:0] c_SLVERR = 2'b10;

   logic                      r_alive;
   logic                      r_aw_held;
   logic                      r_w_held;
   logic                      r_bvalid;
   logic                      r_rvalid;
   logic [ADDRESS_WIDTH-1:0]  r_awaddr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [c_STRB_W-1:0]       r_wstrb;
   logic [1:0]                r_bresp;
   logic [1:0]                r_rresp;
   logic [DATA_WIDTH-1:0]     r_rdata;

   logic                      w_awready;
   logic                      w_wready;
   logic                      w_arready;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_ar_hs;
   logic                      w_b_hs;
   logic                      w_r_hs;
   logic                      w_commit;
   logic [ADDRESS_WIDTH-1:0]  w_aw_idx;
   logic [ADDRESS_WIDTH-1:0]  w_ar_idx;
   logic                      w_aw_in_range;
   logic                      w_ar_in_range;
   logic [1:0]                w_bresp;
   logic [1:0]                w_rresp;
   logic [DATA_WIDTH-1:0]     w_rd_data;
   logic                      w_unused;

   // r_alive keeps every ready low while reset is held, without using ARESETn combinationally
   assign w_awready = r_alive & ~r_aw_held & ~r_bvalid;
   assign w_wready  = r_alive & ~r_w_held  & ~r_bvalid;
   assign w_arready = r_alive & ~r_rvalid;

   assign w_aw_hs  = s_axi.AWVALID & w_awready;
   assign w_w_hs   = s_axi.WVALID  & w_wready;
   assign w_ar_hs  = s_axi.ARVALID & w_arready;
   assign w_b_hs   = r_bvalid & s_axi.BREADY;
   assign w_r_hs   = r_rvalid & s_axi.RREADY;
   assign w_commit = r_aw_held & r_w_held;

   assign w_aw_idx      = r_awaddr >> c_OFFS;
   assign w_ar_idx      = s_axi.ARADDR >> c_OFFS;
   assign w_aw_in_range = w_aw_idx < ADDRESS_WIDTH'(NUM_REGS);
   assign w_ar_in_range = w_ar_idx < ADDRESS_WIDTH'(NUM_REGS);

`ifdef AXIL_SLV_DECODE_ERR_EN
   assign w_bresp = w_aw_in_range ? c_OKAY : c_SLVERR;
   assign w_rresp = w_ar_in_range ? c_OKAY : c_SLVERR;
`else
   assign w_bresp = c_OKAY;
   assign w_rresp = c_OKAY;
`endif

   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, r_awaddr[c_OFFS-1:0], s_axi.ARADDR[c_OFFS-1:0], c_SLVERR};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_alive   <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_alive <= 1'b1;
         if (w_aw_hs) begin
            r_awaddr  <= s_axi.AWADDR;
            r_aw_held <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata  <= s_axi.WDATA;
            r_wstrb  <= s_axi.WSTRB;
            r_w_held <= 1'b1;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_bresp;
         end else if (w_b_hs) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read data is captured from reg_q at the AR edge, so a same-edge commit is not seen
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ar_in_range && (w_ar_idx == ADDRESS_WIDTH'(i))) begin
            w_rd_data = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rresp;
      end else if (w_r_hs) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] r_q;
      logic                  r_wr;

      assign w_hit = w_commit & w_aw_in_range & (w_aw_idx == ADDRESS_WIDTH'(i));

      always_ff @(posedge ACLK or negedge ARESETn) begin
         if (!ARESETn) begin
            r_q  <= '0;
            r_wr <= 1'b0;
         end else begin
            r_wr <= w_hit;
            for (int b = 0; b < c_STRB_W; b++) begin
               if (w_hit && r_wstrb[b]) begin
                  r_q[8*b +: 8] <= r_wdata[8*b +: 8];
               end
            end
         end
      end

      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_q;
      assign reg_wr[i]                         = r_wr;
   end

   assign s_axi.AWREADY = w_awready;
   assign s_axi.WREADY  = w_wready;
   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign s_axi.ARREADY = w_arready;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_slave_regfile
//  Brief    : Vector table, random traffic against an array model, reset cases.
//  Revision : 1.0
// ============================================================================
module tb_axi_lite_slave_regfile;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 16;
`ifdef AXIL_SLV_DECODE_ERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_lite_slave_regfile_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr;

   axi_lite_slave_regfile #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .s_axi   (bus),
      .reg_q   (reg_q),
      .reg_wr  (reg_wr)
   );

   typedef struct {
      logic [31:0]   addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      int            lead;     // >0: W leads AW by this many cycles, <0: AW leads
      int            b_delay;
      int            r_delay;
      logic [1:0]    exp_bresp;
      logic [NR-1:0] exp_wr;
      logic [31:0]   exp_rd;
      logic [1:0]    exp_rresp;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] model [NR];
   int          n_pass  = 0;
   int          n_total = 0;

   logic [1:0]    bresp, rresp;
   logic [NR-1:0] wr_at_b, wr_after;
   logic [31:0]   rdata, raddr, rnd_addr, rnd_data;
   logic [3:0]    rnd_strb;
   bit            rdy_low, b_stable, r_stable, ar_low, hs;
   int            lead, budget;

   function automatic vec_t mk(input logic [31:0] a, d, input logic [3:0] s, input int l, bd, rd,
                               input logic [1:0] eb, input logic [NR-1:0] ew,
                               input logic [31:0] er, input logic [1:0] err);
      vec_t v;
      v.addr = a; v.data = d; v.strb = s; v.lead = l; v.b_delay = bd; v.r_delay = rd;
      v.exp_bresp = eb; v.exp_wr = ew; v.exp_rd = er; v.exp_rresp = err;
      return v;
   endfunction

   function automatic logic [NR*DW-1:0] flat();
      logic [NR*DW-1:0] r;
      for (int i = 0; i < NR; i++) r[i*DW +: DW] = model[i];
      return r;
   endfunction

   function automatic void model_write(input logic [31:0] a, d, input logic [3:0] s);
      int idx;
      idx = int'(a >> 2);
      if (idx < NR) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int idx;
      idx = int'(a >> 2);
      return (idx < NR) ? model[idx] : 32'h0;
   endfunction

   task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: got no handshake expected one within budget", name);
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, data, input logic [3:0] strb,
                           input int lead_c, b_delay, input bit send_aw, send_w,
                           output logic [1:0] resp, output logic [NR-1:0] wr_b,
                           output logic [NR-1:0] wr_nx, output bit rl, output bit bs);
      bit aw_done, w_done, aw_hs, w_hs;
      int t, aw_start, w_start, bud;
      aw_done = !send_aw; w_done = !send_w; rl = 1; bs = 1;
      resp = 2'bxx; wr_b = '0; wr_nx = '0;
      aw_start = (lead_c > 0) ? lead_c : 0;
      w_start  = (lead_c < 0) ? -lead_c : 0;
      bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
      t = 0;
      while (!(aw_done && w_done) && t < 50) begin
         if (!aw_done && t >= aw_start) bus.AWVALID = 1'b1;
         if (!w_done && t >= w_start) bus.WVALID = 1'b1;
         aw_hs = bus.AWVALID && bus.AWREADY;
         w_hs  = bus.WVALID && bus.WREADY;
         step();
         t++;
         if (aw_hs) begin bus.AWVALID = 1'b0; aw_done = 1; end
         if (w_hs) begin bus.WVALID = 1'b0; w_done = 1; end
         if ((send_aw && aw_done && bus.AWREADY) || (send_w && w_done && bus.WREADY)) rl = 0;
      end
      if (!(aw_done && w_done)) begin
         bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
         timeout("write_addr_data");
         return;
      end
      bud = 0;
      while (!bus.BVALID && bud < 50) begin
         step();
         bud++;
         if ((send_aw && bus.AWREADY) || (send_w && bus.WREADY)) rl = 0;
      end
      if (!bus.BVALID) begin
         timeout("write_response");
         return;
      end
      resp = bus.BRESP;
      wr_b = reg_wr;
      for (int k = 0; k < b_delay; k++) begin
         step();
         if (!bus.BVALID || bus.BRESP !== resp) bs = 0;
         if ((send_aw && bus.AWREADY) || (send_w && bus.WREADY)) rl = 0;
      end
      bus.BREADY = 1'b1;
      step();
      bus.BREADY = 1'b0;
      wr_nx = reg_wr;
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_delay,
                          output logic [31:0] data, output logic [1:0] resp,
                          output bit st, output bit al);
      int bud;
      bit h;
      st = 1; al = 1; data = 'x; resp = 'x;
      bus.ARADDR = addr; bus.ARVALID = 1'b1;
      bud = 0; h = 0;
      while (!h && bud < 50) begin
         h = bus.ARREADY;
         step();
         bud++;
      end
      bus.ARVALID = 1'b0;
      if (!h) begin
         timeout("read_addr");
         return;
      end
      bud = 0;
      while (!bus.RVALID && bud < 50) begin
         step();
         bud++;
      end
      if (!bus.RVALID) begin
         timeout("read_data");
         return;
      end
      data = bus.RDATA;
      resp = bus.RRESP;
      for (int k = 0; k < r_delay; k++) begin
         if (bus.ARREADY) al = 0;
         step();
         if (!bus.RVALID || bus.RDATA !== data || bus.RRESP !== resp) st = 0;
      end
      if (bus.ARREADY) al = 0;
      bus.RREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

   initial begin
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
      bus.WDATA  = '0; bus.WSTRB  = '0; bus.WVALID  = 1'b0; bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = '0;

      vecs[0] = mk(32'h08, 32'hDEADBEEF, 4'hF,  0, 0, 0, 2'b00, 16'h0004, 32'hDEADBEEF, 2'b00);
      vecs[1] = mk(32'h04, 32'hAABBCCDD, 4'hF,  0, 5, 4, 2'b00, 16'h0002, 32'hAABBCCDD, 2'b00);
      vecs[2] = mk(32'h04, 32'h11223344, 4'h5,  3, 0, 0, 2'b00, 16'h0002, 32'hAA22CC44, 2'b00);
      vecs[3] = mk(32'h08, 32'h00000000, 4'h0, -2, 0, 0, 2'b00, 16'h0004, 32'hDEADBEEF, 2'b00);
      vecs[4] = mk(32'h3C, 32'h12345678, 4'hC,  1, 0, 0, 2'b00, 16'h8000, 32'h12340000, 2'b00);
      vecs[5] = mk(32'h40, 32'hFFFFFFFF, 4'hF,  0, 0, 0, OOR_RESP, 16'h0000, 32'h00000000, OOR_RESP);
      vecs[6] = mk(32'h0B, 32'h55667788, 4'h2, -1, 0, 0, 2'b00, 16'h0004, 32'hDEAD77EF, 2'b00);

      // Reset state
      repeat (3) @(posedge ACLK);
      #1;
      check("reset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                              bus.BRESP, bus.RRESP, bus.RDATA, reg_wr}, '0);
      check("reset_reg_q", reg_q, '0);
      @(negedge ACLK) ARESETn = 1'b1;
      step();
      step();
      check("idle_ready_valid", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 5'b11100);
      check("idle_reg_q", reg_q, '0);

      // Directed vectors
      for (int v = 0; v < 7; v++) begin
         do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].lead, vecs[v].b_delay,
                  1'b1, 1'b1, bresp, wr_at_b, wr_after, rdy_low, b_stable);
         model_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
         check($sformatf("vec%0d_bresp", v), bresp, vecs[v].exp_bresp);
         check($sformatf("vec%0d_reg_wr_pulse", v), wr_at_b, vecs[v].exp_wr);
         check($sformatf("vec%0d_reg_wr_after", v), wr_after, '0);
         check($sformatf("vec%0d_ready_low_while_busy", v), rdy_low, 1'b1);
         check($sformatf("vec%0d_b_stable", v), b_stable, 1'b1);
         check($sformatf("vec%0d_reg_q", v), reg_q, flat());
         do_read(vecs[v].addr, vecs[v].r_delay, rdata, rresp, r_stable, ar_low);
         check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rd);
         check($sformatf("vec%0d_rresp", v), rresp, vecs[v].exp_rresp);
         check($sformatf("vec%0d_r_stable", v), r_stable, 1'b1);
         check($sformatf("vec%0d_arready_low", v), ar_low, 1'b1);
      end

      // Random traffic against the array model
      for (int n = 0; n < 40; n++) begin
         rnd_addr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
         rnd_data = $urandom;
         rnd_strb = 4'($urandom_range(0, 15));
         lead     = int'($urandom_range(0, 6)) - 3;
         do_write(rnd_addr, rnd_data, rnd_strb, lead, int'($urandom_range(0, 2)),
                  1'b1, 1'b1, bresp, wr_at_b, wr_after, rdy_low, b_stable);
         model_write(rnd_addr, rnd_data, rnd_strb);
         check("rnd_bresp", bresp, ((rnd_addr >> 2) < NR) ? 2'b00 : OOR_RESP);
         check("rnd_reg_wr", wr_at_b, ((rnd_addr >> 2) < NR) ? (NR'(1) << (rnd_addr >> 2)) : '0);
         check("rnd_reg_q", reg_q, flat());
         raddr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
         do_read(raddr, int'($urandom_range(0, 2)), rdata, rresp, r_stable, ar_low);
         check("rnd_rdata", rdata, model_read(raddr));
         check("rnd_rresp", rresp, ((raddr >> 2) < NR) ? 2'b00 : OOR_RESP);
      end

      // Reset after AW handshake, before W
      bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
      budget = 0; hs = 0;
      while (!hs && budget < 50) begin
         hs = bus.AWREADY;
         step();
         budget++;
      end
      bus.AWVALID = 1'b0;
      if (!hs) timeout("midreset_aw");
      ARESETn = 1'b0;
      #1;
      check("midreset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                 bus.BRESP, bus.RRESP, bus.RDATA, reg_wr}, '0);
      check("midreset_reg_q", reg_q, '0);
      for (int i = 0; i < NR; i++) model[i] = '0;
      repeat (2) step();
      @(negedge ACLK) ARESETn = 1'b1;
      step();
      step();

      // A lone W must not pair with the abandoned AW
      bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      budget = 0; hs = 0;
      while (!hs && budget < 50) begin
         hs = bus.WREADY;
         step();
         budget++;
      end
      bus.WVALID = 1'b0;
      if (!hs) timeout("midreset_w");
      repeat (5) step();
      check("lone_w_no_commit", {bus.BVALID, reg_wr, reg_q}, '0);

      // A fresh AW to 0x0 completes the write using the held W
      do_write(32'h0, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0, bresp, wr_at_b, wr_after, rdy_low, b_stable);
      model_write(32'h0, 32'hCAFEF00D, 4'hF);
      check("fresh_aw_bresp", bresp, 2'b00);
      check("fresh_aw_reg_wr", wr_at_b, 16'h0001);
      check("fresh_aw_reg_q", reg_q, flat());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
- AXI4-Lite responder (slave end) terminating the master side of the AXI4-Lite interface.
- Implements a bank of NUM_REGS memory-mapped, byte-strobed, read/write registers.
- Contents are exported flat to surrounding logic, with a per-register write pulse.
- Completes bus-master register accesses in peripheral and testbench integrations.

Parameters:
- DATA_WIDTH, 32, bus and register width in bits; 32 or 64 only.
- ADDRESS_WIDTH, 32, bus address width in bits.
- NUM_REGS, 16, number of registers; must be at least 1.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWADDR  in  ADDRESS_WIDTH  write address
- AWPROT  in  3  ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDRESS_WIDTH  read address
- ARPROT  in  3  ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- reg_wr  out  NUM_REGS  one-cycle pulse per register written

Behaviour:
- Clocking and reset:
  - Single clock ACLK; reset is asynchronous and active-low on ARESETn.
  - While ARESETn is low, all outputs are 0, all registers are 0, and all holding flags are cleared.
  - Reset asserted mid-transaction abandons the transaction; no response is issued after reset release.
- Address decode:
  - idx = ADDR >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - Address is in range when idx < NUM_REGS.
- Write path (independent AW and W holding registers):
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. Both combinational from flops only; they never depend on AWVALID or WVALID.
  - An AW handshake latches AWADDR and sets aw_held. A W handshake latches WDATA and WSTRB and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - On the first edge where both aw_held and w_held are set:
    - commit the write: for each set strobe bit b, update byte b of the target register;
    - pulse reg_wr[idx] for exactly one cycle;
    - set BVALID and clear both held flags.
  - A full-strobe write and a zero-strobe write both return OKAY; a zero-strobe write leaves data unchanged but still pulses reg_wr.
  - BVALID and BRESP stay stable until BREADY; BVALID clears on the B handshake.
  - Minimum write occupancy is 3 cycles: accept, commit/response, ready again.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA is loaded from the register contents at that edge (pre-write value if a write commits on the same edge) and RVALID is set the next cycle.
  - RDATA and RRESP stay stable until RREADY. With RREADY held high, one read completes every 2 cycles.
- Read and write channels operate concurrently and never block each other.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.

Optional Feature:
- Macro: AXIL_SLV_DECODE_ERR_EN.
- Defined:
  - An out-of-range write is dropped (no register change, no reg_wr pulse) and returns BRESP = SLVERR.
  - An out-of-range read returns RDATA = 0 with RRESP = SLVERR.
- Undefined:
  - Out-of-range writes are silently dropped with BRESP = OKAY.
  - Out-of-range reads return 0 with RRESP = OKAY.
- In-range accesses behave identically in both builds.

Test Plan:
- Reset, then idle:
  - AWREADY = WREADY = ARREADY = 1; BVALID = RVALID = 0; reg_q = 0.
- AW and W in the same cycle: addr 0x8, data 0xDEADBEEF, strobe 0xF, BREADY = 1:
  - reg 2 = 0xDEADBEEF; reg_wr = 0x0004 for one cycle; BRESP = 00.
  - A following read of 0x8 returns 0xDEADBEEF, RRESP = 00.
- W three cycles before AW: data 0x11223344, strobe 0x5, addr 0x4, reg 1 initially 0xAABBCCDD:
  - WREADY drops after the W handshake; reg 1 = 0xAA22CC44.
- Backpressure: BREADY = 0 for 5 cycles, then 1; RREADY = 0 for 4 cycles, then 1:
  - BVALID, BRESP, RVALID and RDATA are held stable throughout.
  - AWREADY, WREADY and ARREADY stay 0 until the respective handshake completes.
- Read of 0x40 with NUM_REGS = 16:
  - RDATA = 0.
  - RRESP = 10 when AXIL_SLV_DECODE_ERR_EN is defined, 00 otherwise.
  - A write to 0x40 leaves reg_q unchanged and gives the matching BRESP.
- Reset mid-write: ARESETn asserted after the AW handshake, before W:
  - All outputs are 0 during reset.
  - After release, a lone W does not commit; a fresh AW plus W to 0x0 writes normally.
